// File: rtl/core_run_scheduler.sv
// core_run_scheduler: launches masked cores, tracks end_process rising edges, counts run cycles and reports completion.
// Optional watchdog: define CORE_RUN_SCHED_WATCHDOG_EN to end a run after TIMEOUT_CYC cycles in RUN.
module core_run_scheduler #(
  parameter int         CNT_W       = 16,
  parameter logic [1:0] STAT_IDLE   = 2'b00,
  parameter logic [1:0] STAT_RUN    = 2'b01,
  parameter int         TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       core_mask,
  input  logic             abort,
  input  logic [3:0]       end_process,
  output logic [1:0]       status0,
  output logic [1:0]       status1,
  output logic [1:0]       status2,
  output logic [1:0]       status3,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [3:0]       done_vec,
  output logic [CNT_W-1:0] cycle_count
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  logic [1:0]       r_state;
  logic [3:0]       r_mask;
  logic [3:0]       r_ep_d;
  logic [3:0]       r_done_vec;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic [1:0]       r_stat [4];
  logic [3:0]       w_edges;
  logic [3:0]       w_vec;
  logic             w_full;
  logic             w_sat;
  logic             w_timeout;
  // Only fresh 0->1 transitions on masked cores count; levels seen at launch are stale.
  assign w_edges = end_process & ~r_ep_d & r_mask;
  assign w_vec   = r_done_vec | w_edges;
  assign w_full  = (w_vec == r_mask);
  assign w_sat   = &r_cnt;
`ifdef CORE_RUN_SCHED_WATCHDOG_EN
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  // Watchdog compiled out; the limit stays a parameter so instantiations match across builds.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif
  // Run FSM: launch, edge tracking, cycle counting and completion/abort reporting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mask     <= '0;
      r_ep_d     <= '0;
      r_done_vec <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      for (int k = 0; k < 4; k++) r_stat[k] <= STAT_IDLE;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_mask     <= core_mask;
          r_done_vec <= '0;
          r_cnt      <= '0;
          r_aborted  <= 1'b0;
          r_busy     <= 1'b1;
          r_state    <= (|core_mask) ? S_LAUNCH : S_DONE;
          r_done     <= ~|core_mask;
          for (int k = 0; k < 4; k++) r_stat[k] <= core_mask[3-k] ? STAT_RUN : STAT_IDLE;
        end
        S_LAUNCH: begin
          r_ep_d <= end_process;
          if (abort) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
            for (int k = 0; k < 4; k++) r_stat[k] <= STAT_IDLE;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_ep_d     <= end_process;
          r_done_vec <= w_vec;
          if (!w_sat) r_cnt <= r_cnt + 1'b1;
          if (abort || w_full || w_timeout) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_aborted <= abort || !w_full;
            for (int k = 0; k < 4; k++) r_stat[k] <= STAT_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  assign status0     = r_stat[0];
  assign status1     = r_stat[1];
  assign status2     = r_stat[2];
  assign status3     = r_stat[3];
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign done_vec    = r_done_vec;
  assign cycle_count = r_cnt;
endmodule

// File: tb/tb_core_run_scheduler.sv
// tb_core_run_scheduler: randomized run transactions checked against a run-level model of the scheduler.
module tb_core_run_scheduler;
  localparam int CNT_W = 16;
  localparam int TO    = 20;
  localparam int INF   = 1000000;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [3:0]       core_mask = '0;
  logic [3:0]       end_process = '0;
  logic [1:0]       status0, status1, status2, status3;
  logic             busy, done, aborted;
  logic [3:0]       done_vec;
  logic [CNT_W-1:0] cycle_count;
  int               n_vec = 0;
  int               n_err = 0;
  int               fin [4];
  int               ab;
  logic [3:0]       stale;

  core_run_scheduler #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .core_mask(core_mask), .abort(abort),
    .end_process(end_process), .status0(status0), .status1(status1), .status2(status2),
    .status3(status3), .busy(busy), .done(done), .aborted(aborted), .done_vec(done_vec),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] stat_now();
    return {status0, status1, status2, status3};
  endfunction

  // status0 serves core0, which is mask bit 3; status3 serves mask bit 0.
  function automatic logic [7:0] stat_exp(input logic [3:0] m);
    return {1'b0, m[3], 1'b0, m[2], 1'b0, m[1], 1'b0, m[0]};
  endfunction

  // Per-bit waveform relative to run cycle c (launch is c=-1): a fresh rise happens at fin[i].
  function automatic logic ep_bit(input int i, input int c);
    if (fin[i] < 0) return stale[i];
    if (stale[i]) return (c <= fin[i] - 2) || (c >= fin[i]);
    return c >= fin[i];
  endfunction

  function automatic logic [3:0] ep_at(input int c);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = ep_bit(i, c);
    return v;
  endfunction

  function automatic logic [3:0] finished_by(input logic [3:0] m, input int c);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m[i] && fin[i] >= 0 && fin[i] <= c;
    return v;
  endfunction

  // One complete run: the model predicts the last RUN cycle e, then every cycle is checked.
  task automatic run_case(input logic [3:0] m);
    int         c_end;
    int         e;
    logic       ab_exp;
    logic [3:0] vfin;
    c_end = -1;
    for (int i = 0; i < 4; i++)
      if (m[i]) c_end = (fin[i] < 0 || c_end == INF) ? INF : (fin[i] > c_end ? fin[i] : c_end);
    e = (c_end < ab) ? c_end : ab;
`ifdef CORE_RUN_SCHED_WATCHDOG_EN
    if (TO - 1 < e) e = TO - 1;
`endif
    ab_exp = (ab == e) || (c_end != e);
    end_process = ep_at(-2);
    core_mask = m;
    start = 1'b1;
    abort = 1'b0;
    tick;
    start = 1'b0;
    core_mask = 4'($urandom);
    if (m == 4'd0) begin
      check("zero_done", done, 1'b1);
      check("zero_busy", busy, 1'b1);
      check("zero_cnt", cycle_count, '0);
      check("zero_dvec", done_vec, 4'd0);
      check("zero_abt", aborted, 1'b0);
      check("zero_stat", stat_now(), 8'd0);
      tick;
      check("zero_done_end", done, 1'b0);
      check("zero_busy_end", busy, 1'b0);
      return;
    end
    check("launch_stat", stat_now(), stat_exp(m));
    check("launch_busy", busy, 1'b1);
    check("launch_done", done, 1'b0);
    check("launch_cnt", cycle_count, '0);
    check("launch_dvec", done_vec, 4'd0);
    check("launch_abt", aborted, 1'b0);
    for (int c = -1; c <= e; c++) begin
      end_process = ep_at(c);
      abort = (c == ab);
      start = ($urandom_range(0, 3) == 0);
      core_mask = 4'($urandom);
      tick;
      vfin = finished_by(m, c);
      check("dvec", done_vec, vfin);
      check("cnt", cycle_count, CNT_W'(c + 1));
      if (c < e) begin
        check("run_done", done, 1'b0);
        check("run_busy", busy, 1'b1);
        check("run_stat", stat_now(), stat_exp(m));
      end else begin
        check("end_done", done, 1'b1);
        check("end_busy", busy, 1'b1);
        check("end_stat", stat_now(), 8'd0);
        check("end_abt", aborted, ab_exp);
      end
    end
    start = 1'b0;
    abort = 1'($urandom);
    tick;
    check("post_done", done, 1'b0);
    check("post_busy", busy, 1'b0);
    check("post_stat", stat_now(), 8'd0);
    check("post_dvec", done_vec, finished_by(m, e));
    check("post_cnt", cycle_count, CNT_W'(e + 1));
    check("post_abt", aborted, ab_exp);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("idle_abort_ign", aborted, ab_exp);
    check("idle_abort_busy", busy, 1'b0);
  endtask

  task automatic set_case(input logic [3:0] s, input int f3, input int f2, input int f1, input int f0, input int a);
    stale = s;
    fin[3] = f3;
    fin[2] = f2;
    fin[1] = f1;
    fin[0] = f0;
    ab = a;
  endtask

  initial begin
    logic [3:0] m;
    logic       open_end;
    rst_n = 1'b0;
    tick;
    tick;
    check("rst_stat", stat_now(), 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_abt", aborted, 1'b0);
    check("rst_dvec", done_vec, 4'd0);
    check("rst_cnt", cycle_count, '0);
    rst_n = 1'b1;
    tick;
    set_case(4'b0000, 5, -1, 9, -1, INF);
    run_case(4'b1010);
    set_case(4'b1111, -1, -1, -1, 4, 8);
    run_case(4'b1111);
    set_case(4'b0000, 3, 3, 3, 3, INF);
    run_case(4'b1111);
    set_case(4'b0000, -1, -1, -1, 2, 7);
    run_case(4'b0011);
    set_case(4'b0000, 0, 0, 0, 0, -1);
    run_case(4'b0110);
    set_case(4'b0000, -1, -1, -1, -1, INF);
    run_case(4'b0000);
    set_case(4'b0000, -1, -1, -1, -1, 110);
    run_case(4'b1000);
    for (int r = 0; r < 40; r++) begin
      m = 4'($urandom);
      stale = 4'($urandom);
      open_end = 1'b0;
      for (int i = 0; i < 4; i++) begin
        fin[i] = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 15));
        if (m[i] && fin[i] < 0) open_end = 1'b1;
      end
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 16)) - 1 : INF;
      if (open_end && ab == INF) ab = int'($urandom_range(0, 15));
      run_case(m);
    end
    core_mask = 4'b1111;
    end_process = 4'b0000;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    check("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    tick;
    check("mrst_stat", stat_now(), 8'd0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_dvec", done_vec, 4'd0);
    check("mrst_cnt", cycle_count, '0);
    rst_n = 1'b1;
    tick;
    check("mrst_done2", done, 1'b0);
    check("mrst_busy2", busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
